// File: rtl/laser310_bank_ctrl_if.sv
// Z80-side bus bundle for the Laser 310 bank controller: CPU strobes/address/data
// in, SRAM upper address and controls plus register readback out.
interface laser310_bank_ctrl_if #(
  parameter int unsigned BANK_BITS = 2
);
  logic [4:0]           Addr;
  logic [7:0]           IO_A;
  logic [7:0]           D;
  logic                 WR_N;
  logic                 RD_N;
  logic                 MREQ_N;
  logic                 IORQ_N;
  logic [BANK_BITS-1:0] RAM_AHI;
  logic                 RAM_CS_N;
  logic                 RAM_OE_N;
  logic                 RAM_WE_N;
  logic [7:0]           DOUT;
  logic                 DOUT_EN;

  modport master (
    output Addr, IO_A, D, WR_N, RD_N, MREQ_N, IORQ_N,
    input  RAM_AHI, RAM_CS_N, RAM_OE_N, RAM_WE_N, DOUT, DOUT_EN
  );

  modport slave (
    input  Addr, IO_A, D, WR_N, RD_N, MREQ_N, IORQ_N,
    output RAM_AHI, RAM_CS_N, RAM_OE_N, RAM_WE_N, DOUT, DOUT_EN
  );
endinterface

// File: rtl/laser310_bank_ctrl.sv
// SRAM decode for 0xB800-0xFFFF with an I/O-mapped bank register paging the
// 0xC000-0xFFFF window; memory-side outputs are combinational from the bus.
module laser310_bank_ctrl #(
  parameter int unsigned BANK_BITS    = 2,
  parameter logic [7:0]  BANK_PORT    = 8'h7F,
  parameter int unsigned DEFAULT_BANK = 3,
  parameter int unsigned FIXED_PAGE   = 2
) (
  input logic                 CLK,
  input logic                 RST,
  laser310_bank_ctrl_if.slave bus
);

  localparam logic [BANK_BITS-1:0] DEF_BANK = BANK_BITS'(DEFAULT_BANK);
  localparam logic [BANK_BITS-1:0] FIX_PAGE = BANK_BITS'(FIXED_PAGE);

  // Captured register fields travel as {en, wp, bank}
  localparam int unsigned FW = BANK_BITS + 2;

  logic                 ws;
  logic                 s1_q, s2_q, s3_q;
  logic                 s1_d, s2_d, s3_d;
  logic [FW-1:0]        d1_q, d2_q;
  logic [FW-1:0]        d1_d, d2_d;
  logic [BANK_BITS-1:0] bank_q, bank_d;
  logic                 en_q, en_d;
  logic                 wp_q, wp_d;
  logic                 wr_pulse;
  logic                 unused_d;

  logic                 port_hit;
  logic                 upper_win;
  logic                 acc_valid;
  logic                 prot_wr;
  logic                 cs_n;

  assign unused_d = ^bus.D;

  // ---------------------------------------------------------------------------
  // Bank register write path
  // ---------------------------------------------------------------------------
  assign port_hit = (bus.IO_A == BANK_PORT);
  assign ws       = ~bus.IORQ_N & ~bus.WR_N & port_hit;
  assign wr_pulse = s2_q & ~s3_q;

  always_comb begin
    s1_d   = ws;
    s2_d   = s1_q;
    s3_d   = s2_q;
    d1_d   = {bus.D[7], bus.D[6], bus.D[BANK_BITS-1:0]};
    d2_d   = d1_q;
    bank_d = bank_q;
    en_d   = en_q;
    wp_d   = wp_q;
    if (wr_pulse) begin
      en_d   = d2_q[FW-1];
      wp_d   = d2_q[FW-2];
      bank_d = d2_q[BANK_BITS-1:0];
    end
  end

  // Stages reset high so a strobe already active at reset release never
  // looks like a fresh rising edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      s3_q   <= 1'b1;
      d1_q   <= '0;
      d2_q   <= '0;
      bank_q <= DEF_BANK;
      en_q   <= 1'b0;
      wp_q   <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      d1_q   <= d1_d;
      d2_q   <= d2_d;
      bank_q <= bank_d;
      en_q   <= en_d;
      wp_q   <= wp_d;
    end
  end

  // ---------------------------------------------------------------------------
  // SRAM decode
  // ---------------------------------------------------------------------------
  assign upper_win = (bus.Addr[4:3] == 2'b11);
  assign acc_valid = ~bus.MREQ_N & (bus.Addr >= 5'b10111) & (bus.RD_N ^ bus.WR_N);
  assign prot_wr   = acc_valid & ~bus.WR_N & upper_win & wp_q;
  assign cs_n      = ~(acc_valid & ~prot_wr);

  always_comb begin
    bus.RAM_CS_N = cs_n;
    bus.RAM_OE_N = cs_n | bus.RD_N;
    bus.RAM_WE_N = cs_n | bus.WR_N;
    if (upper_win) begin
      bus.RAM_AHI = en_q ? bank_q : DEF_BANK;
    end else begin
      bus.RAM_AHI = FIX_PAGE;
    end
  end

  // ---------------------------------------------------------------------------
  // Register readback
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.DOUT                  = '0;
    bus.DOUT[7]               = en_q;
    bus.DOUT[6]               = wp_q;
    bus.DOUT[BANK_BITS-1:0]   = bank_q;
    bus.DOUT_EN               = ~bus.IORQ_N & ~bus.RD_N & port_hit;
  end

endmodule

// File: tb/tb_laser310_bank_ctrl.sv
// Directed bench for laser310_bank_ctrl: decode vector table plus hand-written
// register write / reset sequences.
module tb_laser310_bank_ctrl;

  logic CLK;
  logic RST;
  int unsigned errors;
  int unsigned checks;

  laser310_bank_ctrl_if #(.BANK_BITS(2)) bus ();

  laser310_bank_ctrl #(
    .BANK_BITS   (2),
    .BANK_PORT   (8'h7F),
    .DEFAULT_BANK(3),
    .FIXED_PAGE  (2)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    logic [4:0] addr;
    logic [7:0] io_a;
    logic       mreq_n;
    logic       iorq_n;
    logic       rd_n;
    logic       wr_n;
    logic [1:0] ahi;
    logic       cs_n;
    logic       oe_n;
    logic       we_n;
    logic       dout_en;
    logic [7:0] dout;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // {ahi, cs_n, oe_n, we_n, dout_en, dout}
  function automatic logic [13:0] outs();
    return {bus.RAM_AHI, bus.RAM_CS_N, bus.RAM_OE_N, bus.RAM_WE_N, bus.DOUT_EN, bus.DOUT};
  endfunction

  task automatic idle();
    bus.Addr   = 5'b00000;
    bus.IO_A   = 8'h00;
    bus.D      = 8'h00;
    bus.WR_N   = 1'b1;
    bus.RD_N   = 1'b1;
    bus.MREQ_N = 1'b1;
    bus.IORQ_N = 1'b1;
  endtask

  task automatic out_w(input logic [7:0] port, input logic [7:0] data, input int unsigned n);
    @(posedge CLK); #1;
    bus.IO_A = port; bus.D = data; bus.IORQ_N = 1'b0; bus.WR_N = 1'b0;
    repeat (n) @(posedge CLK);
    #1 idle();
    repeat (3) @(posedge CLK);
    #1;
  endtask

  task automatic mem_rd(input logic [4:0] a);
    idle();
    bus.Addr = a; bus.MREQ_N = 1'b0; bus.RD_N = 1'b0;
    #2;
  endtask

  task automatic io_rd(input logic [7:0] port);
    idle();
    bus.IO_A = port; bus.IORQ_N = 1'b0; bus.RD_N = 1'b0;
    #2;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    idle();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;

    // Table assumes register = 0xC0 (en=1, wp=1, bank=0)
    tbl[0]  = '{"rd_c000",     5'b11000, 8'h00, 0, 1, 0, 1, 2'd0, 0, 0, 1, 0, 8'hC0};
    tbl[1]  = '{"wr_prot",     5'b11111, 8'h00, 0, 1, 1, 0, 2'd0, 1, 1, 1, 0, 8'hC0};
    tbl[2]  = '{"rd_prot_adr", 5'b11111, 8'h00, 0, 1, 0, 1, 2'd0, 0, 0, 1, 0, 8'hC0};
    tbl[3]  = '{"wr_fixed",    5'b10111, 8'h00, 0, 1, 1, 0, 2'd2, 0, 1, 0, 0, 8'hC0};
    tbl[4]  = '{"rd_b000",     5'b10110, 8'h00, 0, 1, 0, 1, 2'd2, 1, 1, 1, 0, 8'hC0};
    tbl[5]  = '{"mreq_hi",     5'b11000, 8'h00, 1, 1, 0, 1, 2'd0, 1, 1, 1, 0, 8'hC0};
    tbl[6]  = '{"rdwr_hi",     5'b11000, 8'h00, 0, 1, 1, 1, 2'd0, 1, 1, 1, 0, 8'hC0};
    tbl[7]  = '{"rdwr_lo",     5'b11000, 8'h00, 0, 1, 0, 0, 2'd0, 1, 1, 1, 0, 8'hC0};
    tbl[8]  = '{"in_7f",       5'b00000, 8'h7F, 1, 0, 0, 1, 2'd2, 1, 1, 1, 1, 8'hC0};
    tbl[9]  = '{"in_7e",       5'b00000, 8'h7E, 1, 0, 0, 1, 2'd2, 1, 1, 1, 0, 8'hC0};
    tbl[10] = '{"rd_low",      5'b00000, 8'h00, 0, 1, 0, 1, 2'd2, 1, 1, 1, 0, 8'hC0};
    tbl[11] = '{"rd_b800",     5'b10111, 8'h00, 0, 1, 0, 1, 2'd2, 0, 0, 1, 0, 8'hC0};

    // Reset state
    @(negedge CLK);
    chk("reset_idle", 32'(outs()), 32'({2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 8'h03}));
    mem_rd(5'b11000);
    chk("reset_rd_c000", 32'(outs()), 32'({2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h03}));
    mem_rd(5'b10111);
    chk("reset_rd_b800_ahi", 32'(bus.RAM_AHI), 32'd2);
    io_rd(8'h7F);
    chk("reset_in", 32'({bus.DOUT_EN, bus.DOUT}), 32'({1'b1, 8'h03}));

    // OUT 0x7F,0x81 with 3-CLK strobe; mapping changes only after edge k+2
    idle();
    @(posedge CLK); #1;
    bus.Addr = 5'b11000; bus.IO_A = 8'h7F; bus.D = 8'h81;
    bus.IORQ_N = 1'b0; bus.WR_N = 1'b0;
    @(posedge CLK); #1 chk("lat_k",   32'(bus.RAM_AHI), 32'd3);
    @(posedge CLK); #1 chk("lat_k1",  32'(bus.RAM_AHI), 32'd3);
    @(posedge CLK); #1 chk("lat_k2",  32'(bus.RAM_AHI), 32'd1);
    idle();
    repeat (3) @(posedge CLK);
    #1 mem_rd(5'b11000);
    chk("bank1_rd", 32'(outs()), 32'({2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h81}));
    io_rd(8'h7F);
    chk("bank1_in", 32'({bus.DOUT_EN, bus.DOUT}), 32'({1'b1, 8'h81}));

    // Decode table with en=1, wp=1, bank=0
    out_w(8'h7F, 8'hC0, 3);
    for (int i = 0; i < 12; i++) begin
      idle();
      bus.Addr   = tbl[i].addr;
      bus.IO_A   = tbl[i].io_a;
      bus.MREQ_N = tbl[i].mreq_n;
      bus.IORQ_N = tbl[i].iorq_n;
      bus.RD_N   = tbl[i].rd_n;
      bus.WR_N   = tbl[i].wr_n;
      @(negedge CLK);
      chk(tbl[i].name, 32'(outs()),
          32'({tbl[i].ahi, tbl[i].cs_n, tbl[i].oe_n, tbl[i].we_n, tbl[i].dout_en, tbl[i].dout}));
    end

    // Wrong port leaves the register alone
    out_w(8'h7E, 8'h85, 3);
    io_rd(8'h7F);
    chk("port_7e_ignored", 32'(bus.DOUT), 32'h0C0);

    // Long strobe with data changing mid-way: one update, first data wins
    idle();
    @(posedge CLK); #1;
    bus.IO_A = 8'h7F; bus.D = 8'h82; bus.IORQ_N = 1'b0; bus.WR_N = 1'b0;
    repeat (5) @(posedge CLK);
    #1 bus.D = 8'h41;
    repeat (5) @(posedge CLK);
    #1 idle();
    repeat (3) @(posedge CLK);
    #1 io_rd(8'h7F);
    chk("long_strobe", 32'(bus.DOUT), 32'h082);
    mem_rd(5'b11000);
    chk("alias_fixed_ahi", 32'(bus.RAM_AHI), 32'd2);

    // Upper data bits beyond the bank width are discarded
    out_w(8'h7F, 8'hFF, 3);
    io_rd(8'h7F);
    chk("wide_data", 32'(bus.DOUT), 32'h0C3);

    // Reset while strobe is asserted, released with strobe still asserted
    idle();
    @(posedge CLK); #1;
    bus.IO_A = 8'h7F; bus.D = 8'h81; bus.IORQ_N = 1'b0; bus.WR_N = 1'b0;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    repeat (4) @(posedge CLK);
    #1 idle();
    repeat (3) @(posedge CLK);
    #1 io_rd(8'h7F);
    chk("rst_strobe_dout", 32'(bus.DOUT), 32'h003);
    mem_rd(5'b11000);
    chk("rst_strobe_ahi", 32'(bus.RAM_AHI), 32'd3);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/laser310_bank_ctrl.md
# laser310_bank_ctrl

Parametrised successor to the fixed 64K RAM decoder for the Laser 310 expansion CPLD. It keeps the combinational SRAM chip-select/OE/WE decode for 0xB800–0xFFFF and adds an I/O-mapped bank register. The register pages the 0xC000–0xFFFF window across an SRAM of 2^(14+BANK_BITS) bytes, with enable and write-protect control. It sits between the Z80 bus and the external SRAM upper address lines.

## Interface
Parameters:
- BANK_BITS, 2, bank number width; legal 1..6; SRAM size 2^(14+BANK_BITS) bytes
- BANK_PORT, 8'h7F, I/O port address of the bank register
- DEFAULT_BANK, 3, page used for 0xC000 window when banking disabled and after reset
- FIXED_PAGE, 2, page used for 0xB800–0xBFFF

Ports:
- CLK  in  1  system clock, ≥4× Z80 clock; one clock, all state on rising edge
- RST  in  1  synchronous, active-high reset
- Addr  in  5  Z80 A15..A11
- IO_A  in  8  Z80 A7..A0
- D  in  8  Z80 data bus (input view)
- WR_N, RD_N, MREQ_N, IORQ_N  in  1 each  Z80 strobes, active low
- RAM_AHI  out  BANK_BITS  SRAM upper address lines (replace A15:A14)
- RAM_CS_N, RAM_OE_N, RAM_WE_N  out  1 each  SRAM controls, active low
- DOUT  out  8  register readback
- DOUT_EN  out  1  high: drive DOUT onto Z80 data bus

## Operation
- Register fields: bank[BANK_BITS-1:0] = D[BANK_BITS-1:0], wp = D[6], en = D[7]; other D bits ignored.
- Write strobe: ws = ~IORQ_N & ~WR_N & (IO_A == BANK_PORT).
- Sync pipeline: ws and D pass through stages s1→s2→s3 (D alongside s1/s2).
- Write pulse wp_p = s2 & ~s3; on wp_p, fields load from D stage s2.
- Exactly one register update per strobe, regardless of strobe length.
- Access valid: MREQ_N=0, Addr ≥ 5'b10111, and exactly one of RD_N/WR_N low. RD_N=WR_N=0 and RD_N=WR_N=1 are invalid.
- Protected write: valid access, WR_N=0, Addr[4:3]=2'b11, wp=1.
- RAM_CS_N = 0 iff access valid and not a protected write.
- RAM_OE_N = RAM_CS_N | RD_N; RAM_WE_N = RAM_CS_N | WR_N.
- RAM_AHI, always driven:
  - Addr[4:3]=2'b11: bank if en=1, else DEFAULT_BANK.
  - otherwise: FIXED_PAGE.
- RAM_AHI, RAM_CS_N, RAM_OE_N, RAM_WE_N, DOUT_EN are combinational from bus inputs plus registered state, so no clock latency on memory cycles.
- DOUT_EN = ~IORQ_N & ~RD_N & (IO_A == BANK_PORT).
- DOUT = {en, wp, zeros, bank}, zero-extended into bits [5:0].

## Timing
- Reset (RST high at an edge): bank=DEFAULT_BANK, en=0, wp=0, DOUT=8'h03 (defaults).
- Reset also sets s1, s2, s3 to 1, so a strobe spanning reset release produces no write.
- Reset wins over a coincident wp_p.
- Outputs are combinational: with no bus cycle after reset, RAM_CS_N=1, RAM_OE_N=1, RAM_WE_N=1, DOUT_EN=0, RAM_AHI=FIXED_PAGE if Addr[4:3]≠11.
- Write latency: ws first sampled high at edge k → s1@k, s2@k+1, register updates at edge k+2. New mapping is visible after k+2.
- Z80 strobe width (≥3 CLK at ratio 4) guarantees D is stable at s2.
- A memory access in the same Z80 cycle as the OUT cannot occur. The next M1 fetch sees the new bank.
- Back-to-back OUTs: each needs ws low for ≥1 sampled edge between strobes; otherwise they merge into one write using the first data.
- BANK_BITS bits of D beyond width are discarded.
- A bank value equal to FIXED_PAGE aliases the fixed window; this is legal.

## Test plan
- Reset, then read 0xC000 (Addr=11000, MREQ_N=0, RD_N=0) → RAM_AHI=3, RAM_CS_N=0, RAM_OE_N=0, RAM_WE_N=1; Addr=10111 → RAM_AHI=2.
- OUT 0x7F,0x81 with 3-CLK strobe → RAM_AHI unchanged until edge k+2, then 0xC000 read gives RAM_AHI=1; IN 0x7F → DOUT_EN=1, DOUT=8'h81.
- OUT 0x7F,0xC0 then write Addr=11111, WR_N=0 → RAM_CS_N=1, RAM_WE_N=1; read same address → RAM_CS_N=0; write Addr=10111 → RAM_CS_N=0, RAM_WE_N=0.
- Addr=10110 or MREQ_N=1 or RD_N=WR_N=1 or RD_N=WR_N=0 → RAM_CS_N=1 in every case.
- OUT to port 0x7E → no register change. A 10-CLK strobe → exactly one update.
- RST asserted while ws held low, released with ws still low → register stays at reset defaults, DOUT=8'h03.
